sfifo_param: RTL and testbench

- Parametrised synchronous FIFO. Successor to the team's fixed 16x8 FIFO.
- Adds generic width and depth, and a selectable output mode (registered or first-word-fall-through).
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.
- Sits between single-clock producer/consumer blocks on the CLK domain.

---
 rtl/sfifo_pkg.sv | 20 ++
 rtl/sfifo_ram.sv | 27 ++
 rtl/sfifo_param.sv | 147 ++++++++++++++
 tb/tb_sfifo_param.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sfifo_pkg;

    localparam int MODE_REG  = 0;
    localparam int MODE_FWFT = 1;

    // Ceiling log2, usable in parameter expressions; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// DW x DEPTH storage array: synchronous write, asynchronous read, no reset.
module sfifo_ram
    import sfifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfifo_param.sv
// Parametrised synchronous FIFO with registered or first-word-fall-through output,
// occupancy count, programmable almost flags, sticky error flags and flush.
module sfifo_param
    import sfifo_pkg::*;
#(
    parameter int  DW       = 8,
    parameter int  DEPTH    = 16,
    parameter int  FWFT     = MODE_REG,
    parameter int  AF_LEVEL = DEPTH - 2,
    parameter int  AE_LEVEL = 2,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          clr,
    input  logic          write,
    input  logic          read,
    input  logic [DW-1:0] iData,
    output logic [DW-1:0] oData,
    output logic          oValid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_CNT  = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT  = (AW + 1)'(AE_LEVEL);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sfifo_param: DEPTH must be a power of two and >= 2");
        end
        if (AF_LEVEL > DEPTH) begin : g_bad_af
            $error("sfifo_param: AF_LEVEL must not exceed DEPTH");
        end
        if (AE_LEVEL >= DEPTH) begin : g_bad_ae
            $error("sfifo_param: AE_LEVEL must be below DEPTH");
        end
    endgenerate

    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_ok, rd_ok, ram_we;
    logic [DW-1:0] ram_rdata;

    // Handshake: a push is taken when write=1 and the FIFO is not full, a pop when
    // read=1 and it is not empty, both judged on pre-edge state; clr overrides both.
    // A request that is refused sets the matching sticky error flag instead.
    assign full         = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign empty        = (wp_q == rp_q);
    assign count        = wp_q - rp_q;
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    assign wr_ok  = write && !full && !clr;
    assign rd_ok  = read && !empty && !clr;
    // RSTn gating keeps a write from landing in the array while reset is held.
    assign ram_we = wr_ok && RSTn;

    sfifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .waddr_i (wp_q[AW-1:0]),
        .wdata_i (iData),
        .raddr_i (rp_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (wr_ok)          wp_d  = wp_q + PTR_ONE;
            if (rd_ok)          rp_d  = rp_q + PTR_ONE;
            if (write && full)  ovf_d = 1'b1;
            if (read && empty)  udf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is shown directly; a write into an empty FIFO appears after its edge.
            assign oData  = ram_rdata;
            assign oValid = !empty;
        end else begin : g_reg
            logic [DW-1:0] odata_q, odata_d;
            logic          ovalid_q, ovalid_d;

            always_comb begin
                odata_d  = odata_q;
                ovalid_d = 1'b0;
                if (clr) begin
                    odata_d = '0;
                end else if (rd_ok) begin
                    odata_d  = ram_rdata;
                    ovalid_d = 1'b1;
                end
            end

            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    odata_q  <= '0;
                    ovalid_q <= 1'b0;
                end else begin
                    odata_q  <= odata_d;
                    ovalid_q <= ovalid_d;
                end
            end

            assign oData  = odata_q;
            assign oValid = ovalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench for sfifo_param: registered-output instance driven against a
// reference queue, plus a first-word-fall-through instance.
module tb_sfifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    // Registered-output instance
    logic          clr = 1'b0, write = 1'b0, read = 1'b0;
    logic [DW-1:0] iData = '0;
    logic [DW-1:0] oData;
    logic          oValid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]    count;

    // First-word-fall-through instance
    logic          f_clr = 1'b0, f_write = 1'b0, f_read = 1'b0;
    logic [DW-1:0] f_iData = '0;
    logic [DW-1:0] f_oData;
    logic          f_oValid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0]    f_count;

    int errors = 0;
    int checks = 0;
    int dut_peak;

    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0, m_udf = 1'b0, m_valid = 1'b0;
    logic [DW-1:0] m_odata = '0;

    always #5 CLK = ~CLK;

    sfifo_param #(.DW(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_reg (
        .CLK(CLK), .RSTn(RSTn), .clr(clr), .write(write), .read(read), .iData(iData),
        .oData(oData), .oValid(oValid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sfifo_param #(.DW(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .CLK(CLK), .RSTn(RSTn), .clr(f_clr), .write(f_write), .read(f_read), .iData(f_iData),
        .oData(f_oData), .oValid(f_oValid), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_valid = 1'b0;
        m_odata = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_aempty"}, 32'(almost_empty), 1);
        check({tag, "_afull"}, 32'(almost_full), 0);
        check({tag, "_ovf"}, 32'(overflow), 0);
        check({tag, "_udf"}, 32'(underflow), 0);
        check({tag, "_ovalid"}, 32'(oValid), 0);
        check({tag, "_odata"}, 32'(oData), 0);
        check({tag, "_f_empty"}, 32'(f_empty), 1);
        check({tag, "_f_ovalid"}, 32'(f_oValid), 0);
        check({tag, "_f_count"}, 32'(f_count), 0);
    endtask

    // One clock of the registered instance: drive, advance the reference, compare.
    task automatic cycle(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        bit acc_w, acc_r;
        write = w;
        read  = r;
        clr   = c;
        iData = d;
        acc_w = w && !c && (mdl_q.size() < DEPTH);
        acc_r = r && !c && (mdl_q.size() > 0);
        if (c) begin
            model_reset();
        end else begin
            if (w && !acc_w) m_ovf = 1'b1;
            if (r && !acc_r) m_udf = 1'b1;
            if (acc_r) exp_q.push_back(mdl_q.pop_front());
            if (acc_w) mdl_q.push_back(d);
            m_valid = acc_r;
        end
        tick();
        write = 1'b0;
        read  = 1'b0;
        clr   = 1'b0;
        if (m_valid && exp_q.size() > 0) m_odata = exp_q.pop_front();
        check("ovalid", 32'(oValid), 32'(m_valid));
        check("odata", 32'(oData), 32'(m_odata));
        check("count", 32'(count), mdl_q.size());
        check("full", 32'(full), 32'(mdl_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(mdl_q.size() == 0));
        check("afull", 32'(almost_full), 32'(mdl_q.size() >= AF));
        check("aempty", 32'(almost_empty), 32'(mdl_q.size() <= AE));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
        if (int'(count) > dut_peak) dut_peak = int'(count);
    endtask

    initial begin
        // Reset
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_values("reset");
        RSTn = 1'b1;

        // Fill, then one write past full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i));
        cycle(1'b1, 1'b0, 1'b0, 8'hAA);

        // Drain, then one read past empty: oData holds 0x0F
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("hold_last", 32'(oData), 32'h0F);

        // Wrap-around
        cycle(1'b0, 1'b0, 1'b1, '0);
        dut_peak = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h20 + i));
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        check("wrap_peak", 32'(dut_peak), 12);

        // Simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, DW'(8'h50 + i));
        check("rw_mid_count", 32'(count), 5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Simultaneous at full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 255)));
        cycle(1'b1, 1'b1, 1'b0, 8'hEE);
        check("rw_full_count", 32'(count), 15);
        check("rw_full_ovf", 32'(overflow), 1);

        // Simultaneous at empty
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, 1'b0, 8'h99);
        check("rw_empty_count", 32'(count), 1);
        check("rw_empty_udf", 32'(underflow), 1);
        cycle(1'b0, 1'b1, 1'b0, '0);

        // Flush with 7 entries and overflow set, write/read in the same cycle
        cycle(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
        cycle(1'b1, 1'b0, 1'b0, 8'hAB);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        check("pre_clr_count", 32'(count), 7);
        cycle(1'b1, 1'b1, 1'b1, 8'hCC);
        check("clr_count", 32'(count), 0);
        check("clr_empty", 32'(empty), 1);
        check("clr_ovf", 32'(overflow), 0);
        cycle(1'b1, 1'b0, 1'b0, 8'h77);
        cycle(1'b0, 1'b1, 1'b0, '0);
        check("post_clr_data", 32'(oData), 32'h77);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h80 + i));
        write = 1'b1;
        read  = 1'b1;
        iData = 8'h8F;
        #3;
        RSTn = 1'b0;
        #1;
        model_reset();
        check_reset_values("midrst");
        tick();
        check_reset_values("midrst_held");
        write = 1'b0;
        read  = 1'b0;
        RSTn  = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 8'h11);
        cycle(1'b0, 1'b1, 1'b0, '0);

        // First-word-fall-through instance
        check("f_idle_valid", 32'(f_oValid), 0);
        f_write = 1'b1;
        f_iData = 8'h5A;
        tick();
        f_iData = 8'h33;
        check("f_first_valid", 32'(f_oValid), 1);
        check("f_first_data", 32'(f_oData), 32'h5A);
        check("f_first_count", 32'(f_count), 1);
        tick();
        f_write = 1'b0;
        check("f_head_hold", 32'(f_oData), 32'h5A);
        check("f_count2", 32'(f_count), 2);
        f_read = 1'b1;
        tick();
        check("f_pop1_data", 32'(f_oData), 32'h33);
        check("f_pop1_valid", 32'(f_oValid), 1);
        tick();
        f_read = 1'b0;
        check("f_pop2_empty", 32'(f_empty), 1);
        check("f_pop2_valid", 32'(f_oValid), 0);
        check("f_udf_clear", 32'(f_underflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
